// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen toward the pixel pipeline.
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int XBITS = 10,
    parameter int YBITS = 10
`ifdef VGA_FRAME_COUNT_EN
    ,
    parameter int FBITS = 8
`endif
);
    logic             pix_tick;
    logic [XBITS-1:0] x;
    logic [YBITS-1:0] y;
    logic             hsync;
    logic             vsync;
    logic             activevideo;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [FBITS-1:0] frame_count;
`endif

    modport master (
`ifdef VGA_FRAME_COUNT_EN
        output frame_count,
`endif
        output pix_tick, x, y, hsync, vsync,
        output activevideo, line_start, frame_start
    );

    modport slave (
`ifdef VGA_FRAME_COUNT_EN
        input frame_count,
`endif
        input pix_tick, x, y, hsync, vsync,
        input activevideo, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator (pixel divider, x/y, syncs).
// Define VGA_FRAME_COUNT_EN to add the frame_count register and output.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int XBITS     = 10,
    parameter int YBITS     = 10,
    parameter int FBITS     = 8
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int WholeLine  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int WholeFrame = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HSyncStart = H_VISIBLE + H_FRONT;
    localparam int HSyncEnd   = HSyncStart + H_SYNC - 1;
    localparam int VSyncStart = V_VISIBLE + V_FRONT;
    localparam int VSyncEnd   = VSyncStart + V_SYNC - 1;
    localparam int DBITS      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DBITS-1:0] DivLast = DBITS'(CLK_DIV - 1);
    localparam logic [XBITS-1:0] XLast   = XBITS'(WholeLine - 1);
    localparam logic [YBITS-1:0] YLast   = YBITS'(WholeFrame - 1);
    localparam logic [XBITS-1:0] XVis    = XBITS'(H_VISIBLE);
    localparam logic [YBITS-1:0] YVis    = YBITS'(V_VISIBLE);
    localparam logic [XBITS-1:0] XSyncLo = XBITS'(HSyncStart);
    localparam logic [XBITS-1:0] XSyncHi = XBITS'(HSyncEnd);
    localparam logic [YBITS-1:0] YSyncLo = YBITS'(VSyncStart);
    localparam logic [YBITS-1:0] YSyncHi = YBITS'(VSyncEnd);
    localparam logic             HPol    = 1'(H_POL);
    localparam logic             VPol    = 1'(V_POL);

    if ((64'd1 << XBITS) < 64'(WholeLine)) begin : g_xbits_err
        $error("XBITS too narrow for WholeLine");
    end
    if ((64'd1 << YBITS) < 64'(WholeFrame)) begin : g_ybits_err
        $error("YBITS too narrow for WholeFrame");
    end
    if (CLK_DIV < 1) begin : g_div_err
        $error("CLK_DIV must be at least 1");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_sync_err
        $error("sync widths must be non-zero");
    end
    if (FBITS < 1) begin : g_fbits_err
        $error("FBITS must be at least 1");
    end

    logic [DBITS-1:0] div_q, div_d;
    logic [XBITS-1:0] x_q, x_d;
    logic [YBITS-1:0] y_q, y_d;
    logic             tick;
    logic             x_end;
    logic             y_end;

    always_comb begin
        x_end = (x_q == XLast);
        y_end = (y_q == YLast);
        tick  = (div_q == DivLast) && !reset;
        div_d = (div_q == DivLast) ? '0 : div_q + DBITS'(1);
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + YBITS'(1);
            end else begin
                x_d = x_q + XBITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    // All decodes come straight off the registers: zero added latency.
    assign vga.pix_tick    = tick;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.hsync       = (x_q >= XSyncLo && x_q <= XSyncHi) ? HPol : ~HPol;
    assign vga.vsync       = (y_q >= YSyncLo && y_q <= YSyncHi) ? VPol : ~VPol;
    assign vga.activevideo = (x_q < XVis) && (y_q < YVis);
    assign vga.line_start  = tick && (x_q == '0);
    assign vga.frame_start = tick && (x_q == '0) && (y_q == '0);

`ifdef VGA_FRAME_COUNT_EN
    logic [FBITS-1:0] fc_q, fc_d;

    always_comb begin
        fc_d = fc_q;
        if (tick && x_end && y_end) begin
            fc_d = fc_q + FBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign vga.frame_count = fc_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, tiny CLK_DIV=1 and
// CLK_DIV=3 configurations, checked against hand-computed values.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_def;
    logic rst_sml;
    logic rst_mid;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if #(
        .XBITS(10),
        .YBITS(10)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .FBITS(2)
`endif
    ) if_sml ();
    vga_timing_gen_if if_mid ();

    vga_timing_gen u_def (
        .clk  (clk),
        .reset(rst_def),
        .vga  (if_def)
    );

    vga_timing_gen #(
        .CLK_DIV(1),
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(1), .V_POL(1),
        .FBITS(2)
    ) u_sml (
        .clk  (clk),
        .reset(rst_sml),
        .vga  (if_sml)
    );

    vga_timing_gen #(
        .CLK_DIV(3),
        .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_mid (
        .clk  (clk),
        .reset(rst_mid),
        .vga  (if_mid)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int k, cnt, hs, av, vs, hmin, hmax;
        int ticks, bad_ls, bad_fs, fs_cnt, vbad, wraps, wbad;
        int fc_bad;
        logic prev_end;
        logic [63:0] fc_prev;

        rst_def = 1'b1;
        rst_sml = 1'b1;
        rst_mid = 1'b1;
        fc_prev = '0;

        // ---------------- default config: reset and first tick
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("def_rst_tick", if_def.pix_tick, 0);
            chk("def_rst_fs", if_def.frame_start, 0);
        end
        rst_def = 1'b0;
        #1;
        chk("def_x0", if_def.x, 0);
        chk("def_y0", if_def.y, 0);
        chk("def_hs0", if_def.hsync, 1);
        chk("def_vs0", if_def.vsync, 1);
        chk("def_av0", if_def.activevideo, 1);
        k = 0;
        while (!if_def.pix_tick && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("def_first_tick_lat", k, 3);
        chk("def_first_fs", if_def.frame_start, 1);

        // ---------------- default config: one line
        cnt = 0; hs = 0; av = 0; hmin = 9999; hmax = 0;
        do begin
            if (!if_def.hsync) begin
                hs++;
                if (int'(if_def.x) < hmin) hmin = int'(if_def.x);
                if (int'(if_def.x) > hmax) hmax = int'(if_def.x);
            end
            if (!if_def.activevideo) av++;
            @(negedge clk);
            cnt++;
        end while (!if_def.line_start && cnt < 5000);
        chk("def_line_period", cnt, 3200);
        chk("def_hs_low_clks", hs, 384);
        chk("def_hs_xmin", hmin, 656);
        chk("def_hs_xmax", hmax, 751);
        chk("def_av_low_clks", av, 640);
        chk("def_y_after_line", if_def.y, 1);
        chk("def_x_after_line", if_def.x, 0);

        // ---------------- default config: mid-frame reset at x=300
        k = 0;
        while (if_def.x != 10'd300 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("def_reach_x300", if_def.x, 300);
        rst_def = 1'b1;
        @(negedge clk);
        chk("def_mrst_x", if_def.x, 0);
        chk("def_mrst_y", if_def.y, 0);
        chk("def_mrst_fs", if_def.frame_start, 0);
`ifdef VGA_FRAME_COUNT_EN
        chk("def_mrst_fc", if_def.frame_count, 0);
`endif
        rst_def = 1'b0;

        // ---------------- tiny config, CLK_DIV = 1, positive syncs
        rst_sml = 1'b0;
        #1;
        chk("sml_first_tick", if_sml.pix_tick, 1);
        chk("sml_first_fs", if_sml.frame_start, 1);
        ticks = 0; bad_ls = 0; bad_fs = 0; fs_cnt = 0;
        hs = 0; vs = 0; vbad = 0; hmin = 9999; hmax = 0;
        wraps = 0; wbad = 0; fc_bad = 0; prev_end = 1'b0;
        for (int i = 0; i < 240; i++) begin
            ticks += int'(if_sml.pix_tick);
            if (if_sml.line_start != ((i % 8) == 0)) bad_ls++;
            if (if_sml.frame_start != ((i % 48) == 0)) bad_fs++;
            if (if_sml.hsync) begin
                hs++;
                if (int'(if_sml.x) < hmin) hmin = int'(if_sml.x);
                if (int'(if_sml.x) > hmax) hmax = int'(if_sml.x);
            end
            if (if_sml.vsync) begin
                vs++;
                if (if_sml.y != 10'd4) vbad++;
            end
            if (prev_end) begin
                wraps++;
                if (if_sml.x != 10'd0 || if_sml.y != 10'd0) wbad++;
            end
`ifdef VGA_FRAME_COUNT_EN
            if (if_sml.frame_start) begin
                chk("sml_fc_at_fs", if_sml.frame_count, fs_cnt % 4);
            end
            if (i > 0 && 64'(if_sml.frame_count) != fc_prev && !prev_end)
                fc_bad++;
            fc_prev = 64'(if_sml.frame_count);
`endif
            if (if_sml.frame_start) fs_cnt++;
            prev_end = (if_sml.x == 10'd7) && (if_sml.y == 10'd5);
            @(negedge clk);
        end
        chk("sml_ticks", ticks, 240);
        chk("sml_ls_pattern_bad", bad_ls, 0);
        chk("sml_fs_pattern_bad", bad_fs, 0);
        chk("sml_fs_count", fs_cnt, 5);
        chk("sml_hs_high_clks", hs, 60);
        chk("sml_hs_xmin", hmin, 5);
        chk("sml_hs_xmax", hmax, 6);
        chk("sml_vs_high_clks", vs, 40);
        chk("sml_vs_wrong_y", vbad, 0);
        chk("sml_wraps", wraps, 4);
        chk("sml_wrap_bad", wbad, 0);
`ifdef VGA_FRAME_COUNT_EN
        chk("sml_fc_off_wrap", fc_bad, 0);
`endif

        // ---------------- CLK_DIV = 3 config: latency and frame period
        rst_mid = 1'b0;
        #1;
        k = 0;
        while (!if_mid.pix_tick && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_first_tick_lat", k, 2);
        chk("mid_first_fs", if_mid.frame_start, 1);
        cnt = 0; hs = 0; vs = 0; av = 0;
        do begin
            if (!if_mid.hsync) hs++;
            if (!if_mid.vsync) vs++;
            if (!if_mid.activevideo) av++;
            @(negedge clk);
            cnt++;
        end while (!if_mid.frame_start && cnt < 2000);
        chk("mid_frame_period", cnt, 600);
        chk("mid_hs_low_clks", hs, 90);
        chk("mid_vs_low_clks", vs, 120);
        chk("mid_av_low_clks", av, 420);

        // ---------------- CLK_DIV = 3 config: mid-frame reset
        k = 0;
        while (!(if_mid.x == 10'd7 && if_mid.y == 10'd4) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reach_7_4", if_mid.y, 4);
        rst_mid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_mrst_x", if_mid.x, 0);
            chk("mid_mrst_y", if_mid.y, 0);
            chk("mid_mrst_tick", if_mid.pix_tick, 0);
            chk("mid_mrst_fs", if_mid.frame_start, 0);
        end
        rst_mid = 1'b0;
        #1;
        k = 0;
        while (!if_mid.pix_tick && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_restart_lat", k, 2);
        chk("mid_restart_fs", if_mid.frame_start, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
